// File: rtl/pixel_pwm_pkg.sv
// Shared definitions for the pixel PWM sequencer.
// Contents: FSM state enum and helper functions that derive the frame geometry
// from DATA_W / MSB_W. The frame is made of thermometer slots followed by
// binary-weighted slots.
package pixel_pwm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Ticks per frame.
    function automatic int frame_len(input int data_w);
        return (1 << data_w) - 1;
    endfunction

    // Number of slots per frame: thermometer slots plus one slot per LSB.
    function automatic int slot_count(input int msb_w, input int lsb_w);
        return (1 << msb_w) - 1 + lsb_w;
    endfunction

    // Length of slot k in ticks. Thermometer slots are 2^lsb_w long.
    // Binary slot j lasts 2^j ticks.
    function automatic int slot_len(input int k, input int msb_w, input int lsb_w);
        int ntherm;
        ntherm = (1 << msb_w) - 1;
        if (k < ntherm) begin
            return 1 << lsb_w;
        end
        return 1 << (k - ntherm);
    endfunction

    // Width of a slot index. It is at least 1 bit so that the one-slot case
    // still has a port.
    function automatic int idx_w(input int msb_w, input int lsb_w);
        int n;
        n = slot_count(msb_w, lsb_w);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_pwm_slot_gen.sv
// Frame timebase for the pixel PWM sequencer.
// The prescale counter divides clk down to ticks. The tick counter measures
// the current slot, and the slot counter walks through the frame.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   run          sequencer is in a frame; all counters hold 0 otherwise
//   clear        abort: counters return to 0 on the next edge
//   slot_idx     current slot
//   slot_bin     current slot is binary-weighted (not thermometer)
//   bin_idx      bit position driven by the current binary slot
//   frame_start  first clk cycle of a frame
//   frame_end    last clk cycle of a frame
module pixel_pwm_slot_gen
    import pixel_pwm_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int MSB_W    = 4,
    parameter int PRESCALE = 1,
    localparam int LSB_W   = DATA_W - MSB_W,
    localparam int NTHERM  = (1 << MSB_W) - 1,
    localparam int NSLOT   = slot_count(MSB_W, DATA_W - MSB_W),
    localparam int SW      = idx_w(MSB_W, DATA_W - MSB_W),
    localparam int BW      = (LSB_W > 1) ? $clog2(LSB_W) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          clear,
    output logic [SW-1:0] slot_idx,
    output logic          slot_bin,
    output logic [BW-1:0] bin_idx,
    output logic          frame_start,
    output logic          frame_end
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TW = (LSB_W > 0) ? LSB_W : 1;

    logic [PW-1:0] pre_reg;
    logic [TW-1:0] tick_reg;
    logic [SW-1:0] slot_reg;
    logic          pre_last;
    logic          tick_last;
    logic          slot_last;

    assign pre_last  = (pre_reg == PW'(PRESCALE - 1));
    assign tick_last = (int'(tick_reg) == slot_len(int'(slot_reg), MSB_W, LSB_W) - 1);
    assign slot_last = (slot_reg == SW'(NSLOT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear || !run) begin
            pre_reg  <= '0;
            tick_reg <= '0;
            slot_reg <= '0;
        end else if (pre_last) begin
            pre_reg <= '0;
            if (tick_last) begin
                tick_reg <= '0;
                // The slot counter wraps only here, at the end of the frame.
                slot_reg <= slot_last ? '0 : slot_reg + 1'b1;
            end else begin
                tick_reg <= tick_reg + 1'b1;
            end
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    assign slot_idx    = slot_reg;
    assign slot_bin    = (int'(slot_reg) >= NTHERM);
    // This value is only meaningful while slot_bin is high.
    assign bin_idx     = BW'(int'(slot_reg) - NTHERM);
    assign frame_start = run && (pre_reg == '0) && (tick_reg == '0) && (slot_reg == '0);
    assign frame_end   = run && pre_last && tick_last && slot_last;

endmodule

// File: rtl/pixel_pwm_seq.sv
// Multi-channel pixel PWM sequencer.
// Each accepted pixel word is played out as one PWM frame of 2^DATA_W-1 ticks
// per channel. A one-deep shadow buffer lets the next word wait, so that
// frames run back-to-back.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   din          CH pixel values, channel c at [c*DATA_W +: DATA_W]
//   din_vld      din valid
//   din_rdy      din can be accepted (shadow empty)
//   flush        abort the current frame and drop the shadow
//   pwm_out      registered per-channel PWM level
//   oe           high while pwm_out carries a frame
//   sof          one-cycle pulse on the first output cycle of a frame
//   slot_idx     slot currently shown on pwm_out
module pixel_pwm_seq
    import pixel_pwm_pkg::*;
#(
    parameter int CH       = 4,
    parameter int DATA_W   = 8,
    parameter int MSB_W    = 4,
    parameter int PRESCALE = 1,
    localparam int LSB_W   = DATA_W - MSB_W,
    localparam int SW      = idx_w(MSB_W, DATA_W - MSB_W),
    localparam int BW      = (LSB_W > 1) ? $clog2(LSB_W) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH*DATA_W-1:0] din,
    input  logic                 din_vld,
    output logic                 din_rdy,
    input  logic                 flush,
    output logic [CH-1:0]        pwm_out,
    output logic                 oe,
    output logic                 sof,
    output logic [SW-1:0]        slot_idx
);

    state_t                state_reg, state_next;
    logic [CH*DATA_W-1:0]  active_reg, active_next;
    logic [CH*DATA_W-1:0]  shadow_reg, shadow_next;
    logic                  shadow_full_reg, shadow_full_next;
    logic                  rdy_reg;
    logic                  accept;

    logic [SW-1:0]         slot_cur;
    logic                  slot_bin;
    logic [BW-1:0]         bin_idx;
    logic                  frame_start;
    logic                  frame_end;

    logic [CH-1:0]         lvl;
    logic                  oe_next, sof_next;
    logic [CH-1:0]         pwm_reg;
    logic                  oe_reg, sof_reg;
    logic [SW-1:0]         slot_reg;

    assign accept  = din_vld && rdy_reg;
    assign din_rdy = rdy_reg;

    pixel_pwm_slot_gen #(
        .DATA_W   (DATA_W),
        .MSB_W    (MSB_W),
        .PRESCALE (PRESCALE)
    ) u_slot_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (state_reg == ST_RUN),
        .clear       (flush),
        .slot_idx    (slot_cur),
        .slot_bin    (slot_bin),
        .bin_idx     (bin_idx),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    // State register. The ready flag is registered from the next shadow
    // state, so it stays low during reset and during the cycle in which the
    // shadow drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            shadow_full_reg <= 1'b0;
            rdy_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            shadow_full_reg <= shadow_full_next;
            rdy_reg         <= !shadow_full_next;
        end
    end

    // The pixel buffers need no reset because they are qualified by the state
    // and by shadow_full.
    always_ff @(posedge clk) begin
        active_reg <= active_next;
        shadow_reg <= shadow_next;
    end

    // Next-state and buffer steering.
    always_comb begin
        state_next       = state_reg;
        active_next      = active_reg;
        shadow_next      = shadow_reg;
        shadow_full_next = shadow_full_reg;
        if (flush) begin
            // flush wins over a same-cycle accept, so that word is dropped.
            state_next       = ST_IDLE;
            shadow_full_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        active_next = din;
                        state_next  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (frame_end) begin
                        if (shadow_full_reg) begin
                            active_next      = shadow_reg;
                            shadow_full_next = 1'b0;
                        end else if (accept) begin
                            active_next = din;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else if (accept) begin
                        shadow_next      = din;
                        shadow_full_next = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode. Thermometer slot k lights a lane when msb > k. Binary
    // slot j shows bit j of the value.
    always_comb begin
        oe_next  = (state_reg == ST_RUN);
        sof_next = frame_start;
    end

    for (genvar gi = 0; gi < CH; gi++) begin : g_lane
        logic [MSB_W-1:0] msb;
        assign msb = active_reg[gi*DATA_W + LSB_W +: MSB_W];
        if (LSB_W > 0) begin : g_mix
            logic [LSB_W-1:0] lsb;
            assign lsb     = active_reg[gi*DATA_W +: LSB_W];
            assign lvl[gi] = (state_reg == ST_RUN) &&
                             (slot_bin ? lsb[bin_idx] : (int'(msb) > int'(slot_cur)));
        end else begin : g_therm
            assign lvl[gi] = (state_reg == ST_RUN) && (int'(msb) > int'(slot_cur));
        end
    end

    // Output register stage: pwm_out, oe, sof and slot_idx stay aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_reg  <= '0;
            oe_reg   <= 1'b0;
            sof_reg  <= 1'b0;
            slot_reg <= '0;
        end else begin
            pwm_reg  <= lvl;
            oe_reg   <= oe_next;
            sof_reg  <= sof_next;
            slot_reg <= slot_cur;
        end
    end

    assign pwm_out  = pwm_reg;
    assign oe       = oe_reg;
    assign sof      = sof_reg;
    assign slot_idx = slot_reg;

endmodule
